// File: rtl/ifm_frame_scheduler_if.sv
// Pixel-stream input and IFM write-bus output of the IFM frame scheduler.
// The master modport is the scheduler's own view of these signals.
interface ifm_frame_scheduler_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDRESS_BUS = 22
);
   logic                   s_valid;
   logic [DATA_WIDTH-1:0]  s_data;
   logic                   s_ready;
   logic [DATA_WIDTH-1:0]  bus_data;
   logic [ADDRESS_BUS-1:0] bus_addr;
   logic                   bus_wr;

   modport master (
      input  s_valid, s_data,
      output s_ready, bus_data, bus_addr, bus_wr
   );

   modport slave (
      output s_valid, s_data,
      input  s_ready, bus_data, bus_addr, bus_wr
   );
endinterface

// File: rtl/ifm_frame_scheduler.sv
// Streams IFM frames into the accelerator's IFM memory over the data bus.
// It paces each frame load on the accelerator's ready edge and counts the returned results.
module ifm_frame_scheduler #(
   parameter int                     DATA_WIDTH   = 32,
   parameter int                     ADDRESS_BUS  = 22,
   parameter int                     ADDRESS_BITS = 15,
   parameter int                     ENABLE_BITS  = 7,
   parameter logic [ENABLE_BITS-1:0] IFM_SEL      = 7'd111,
   parameter int                     IFM_WORDS    = 1024
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [7:0]                  num_frames,
   ifm_frame_scheduler_if.master       io,
   input  logic                        acc_ready,
   input  logic                        acc_done,
   output logic                        initialization_done,
   output logic                        frame_done,
   output logic [7:0]                  frame_idx,
   output logic                        busy,
   output logic                        all_done
);

   localparam logic [ADDRESS_BITS-1:0] LAST_WORD = ADDRESS_BITS'(IFM_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      KICK,
      WAIT_RDY,
      DRAIN
   } state_t;

   state_t                  state;
   state_t                  state_nx;

   logic [ADDRESS_BITS-1:0] load_cnt;
   logic [7:0]              frames_total;
   logic [7:0]              frames_loaded;
   logic [7:0]              results;
   logic [7:0]              results_nx;
   logic                    acc_ready_q;
   logic                    acc_done_q;

   logic [DATA_WIDTH-1:0]   bus_data_q;
   logic [ADDRESS_BUS-1:0]  bus_addr_q;
   logic                    bus_wr_q;

   logic                    accept;
   logic                    last_word;
   logic                    rdy_edge;
   logic                    done_edge;
   logic                    count_result;
   logic                    job_start;
   logic                    finish_job;

   assign io.s_ready = (state == LOAD);
   assign io.bus_data = bus_data_q;
   assign io.bus_addr = bus_addr_q;
   assign io.bus_wr   = bus_wr_q;
   assign busy        = (state != IDLE);

   // Edges are taken against the value registered on the previous clock.
   assign rdy_edge     = acc_ready && !acc_ready_q;
   assign done_edge    = acc_done && !acc_done_q;
   assign accept       = io.s_valid && (state == LOAD);
   assign last_word    = accept && (load_cnt == LAST_WORD);
   assign count_result = done_edge && (state != IDLE) && (results < frames_total);
   assign results_nx   = results + {7'd0, count_result};
   assign job_start    = (state == IDLE) && start && (num_frames != 8'd0);

   // NOTE: every signal written here gets its default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nx   = state;
      finish_job = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (num_frames != 8'd0) state_nx = LOAD;
               else                    finish_job = 1'b1;
            end
         end
         LOAD: begin
            if (last_word) state_nx = KICK;
         end
         KICK: begin
            if (frames_loaded < frames_total) state_nx = WAIT_RDY;
            else                              state_nx = DRAIN;
         end
         WAIT_RDY: begin
            if (rdy_edge) state_nx = LOAD;
         end
         DRAIN: begin
            // The look-ahead count lets a result arriving in this very cycle close the job.
            if (results_nx == frames_total) begin
               state_nx   = IDLE;
               finish_job = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         load_cnt            <= '0;
         frames_total        <= '0;
         frames_loaded       <= '0;
         results             <= '0;
         acc_ready_q         <= 1'b0;
         acc_done_q          <= 1'b0;
         bus_data_q          <= '0;
         bus_addr_q          <= '0;
         bus_wr_q            <= 1'b0;
         initialization_done <= 1'b0;
         frame_done          <= 1'b0;
         frame_idx           <= '0;
         all_done            <= 1'b0;
      end else begin
         acc_ready_q         <= acc_ready;
         acc_done_q          <= acc_done;
         bus_wr_q            <= accept;
         initialization_done <= (state == KICK);
         frame_done          <= count_result;
         all_done            <= finish_job;
         results             <= results_nx;

         if (count_result) frame_idx <= results;

         // An idle bus cycle carries select 0, so no unit is enabled; the data lines keep their value.
         if (accept) begin
            bus_data_q <= io.s_data;
            bus_addr_q <= {IFM_SEL, load_cnt};
         end else begin
            bus_addr_q <= '0;
         end

         if (job_start) begin
            frames_total  <= num_frames;
            frames_loaded <= '0;
            results       <= '0;
            load_cnt      <= '0;
         end else if (accept) begin
            if (last_word) begin
               load_cnt      <= '0;
               frames_loaded <= frames_loaded + 8'd1;
            end else begin
               load_cnt <= load_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ifm_frame_scheduler.sv
// Directed job sequence with random pixel data and random source stalls.
// Bus writes, pulses and result indices are compared against the frame-loading rules.
module tb_ifm_frame_scheduler;

   localparam int            DW          = 32;
   localparam int            AB          = 22;
   localparam int            WORDS       = 1024;
   localparam logic [AB-1:0] IFM_BASE    = 22'h378000;
   localparam int            FRAME_LIMIT = 6000;

   logic       clk        = 1'b0;
   logic       reset      = 1'b0;
   logic       start      = 1'b0;
   logic [7:0] num_frames = 8'd0;
   logic       acc_ready  = 1'b0;
   logic       acc_done   = 1'b0;
   logic       initialization_done;
   logic       frame_done;
   logic [7:0] frame_idx;
   logic       busy;
   logic       all_done;

   ifm_frame_scheduler_if #(.DATA_WIDTH(DW), .ADDRESS_BUS(AB)) io ();

   ifm_frame_scheduler #(
      .DATA_WIDTH   (DW),
      .ADDRESS_BUS  (AB),
      .ADDRESS_BITS (15),
      .ENABLE_BITS  (7),
      .IFM_SEL      (7'd111),
      .IFM_WORDS    (WORDS)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .start               (start),
      .num_frames          (num_frames),
      .io                  (io.master),
      .acc_ready           (acc_ready),
      .acc_done            (acc_done),
      .initialization_done (initialization_done),
      .frame_done          (frame_done),
      .frame_idx           (frame_idx),
      .busy                (busy),
      .all_done            (all_done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int feed_pct = 0;
   int start_cyc = 0;
   int edge_cyc = 0;

   // Observation log, filled at every falling edge.
   logic [AB-1:0] wr_addr_q[$];
   logic [DW-1:0] wr_data_q[$];
   int            wr_cyc_q[$];
   logic [DW-1:0] acc_data_q[$];
   int            acc_cyc_q[$];
   logic [7:0]    fd_idx_q[$];
   int            init_cnt = 0;
   int            init_cyc = 0;
   int            all_done_cnt = 0;
   int            all_done_cyc = 0;
   int            busy_cnt = 0;
   int            addr_viol = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Pixel source: offers a fresh random word with probability feed_pct each cycle.
   initial begin
      io.s_valid = 1'b0;
      io.s_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         io.s_valid = (feed_pct != 0) && (int'($urandom_range(99)) < feed_pct);
         io.s_data  = $urandom;
      end
   end

   initial forever begin
      @(negedge clk);
      if (io.bus_wr) begin
         wr_addr_q.push_back(io.bus_addr);
         wr_data_q.push_back(io.bus_data);
         wr_cyc_q.push_back(cyc);
      end else if (io.bus_addr !== '0) begin
         addr_viol++;
      end
      if (io.s_valid && io.s_ready) begin
         acc_data_q.push_back(io.s_data);
         acc_cyc_q.push_back(cyc);
      end
      if (initialization_done) begin
         init_cnt++;
         init_cyc = cyc;
      end
      if (all_done) begin
         all_done_cnt++;
         all_done_cyc = cyc;
      end
      if (frame_done) fd_idx_q.push_back(frame_idx);
      if (busy) busy_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
      acc_data_q.delete();
      acc_cyc_q.delete();
      fd_idx_q.delete();
      init_cnt     = 0;
      init_cyc     = 0;
      all_done_cnt = 0;
      all_done_cyc = 0;
      busy_cnt     = 0;
   endtask

   task automatic do_start(input logic [7:0] nf);
      num_frames = nf;
      start      = 1'b1;
      start_cyc  = cyc;
      tick(1);
      start      = 1'b0;
   endtask

   task automatic pulse_done();
      acc_done = 1'b1;
      tick(2);
      acc_done = 1'b0;
      tick(3);
   endtask

   task automatic wait_init(input int n, input string tag);
      for (int i = 0; i < FRAME_LIMIT && init_cnt < n; i++) tick(1);
      check(tag, init_cnt, n);
   endtask

   task automatic wait_all(input string tag);
      for (int i = 0; i < 200 && all_done_cnt < 1; i++) tick(1);
      check(tag, all_done_cnt, 1);
   endtask

   // Expected stream: write n goes to IFM_BASE + (n mod WORDS) with the n-th accepted word, one cycle later.
   task automatic check_writes(input string tag, input int nframes);
      int n;
      int bad_a;
      int bad_d;
      int bad_l;
      n     = wr_addr_q.size();
      bad_a = 0;
      bad_d = 0;
      bad_l = 0;
      check({tag, " write count"}, n, nframes * WORDS);
      check({tag, " accept count"}, acc_data_q.size(), n);
      for (int i = 0; i < n; i++) begin
         if (wr_addr_q[i] !== IFM_BASE + AB'(i % WORDS)) bad_a++;
         if (i < acc_data_q.size()) begin
            if (wr_data_q[i] !== acc_data_q[i]) bad_d++;
            if (wr_cyc_q[i] != acc_cyc_q[i] + 1) bad_l++;
         end
      end
      check({tag, " bad addresses"}, bad_a, 0);
      check({tag, " bad data"}, bad_d, 0);
      check({tag, " bad latency"}, bad_l, 0);
   endtask

   task automatic check_results(input string tag, input int n);
      int bad;
      bad = 0;
      check({tag, " frame_done count"}, fd_idx_q.size(), n);
      for (int i = 0; i < fd_idx_q.size(); i++)
         if (fd_idx_q[i] != 8'(i)) bad++;
      check({tag, " bad frame_idx"}, bad, 0);
   endtask

   initial begin
      // Reset state
      tick(3);
      check("rst flags", {io.bus_wr, io.s_ready, initialization_done, frame_done, busy, all_done}, 6'b0);
      check("rst bus_addr", io.bus_addr, 0);
      check("rst bus_data", io.bus_data, 0);
      check("rst frame_idx", frame_idx, 0);
      reset = 1'b1;
      tick(2);
      clear_log();

      // Single frame, continuous source
      feed_pct = 100;
      do_start(8'd1);
      check("t1 loading", {busy, io.s_ready}, 2'b11);
      wait_init(1, "t1 init");
      tick(5);
      check_writes("t1", 1);
      check("t1 first addr", wr_addr_q[0], IFM_BASE);
      check("t1 last addr", wr_addr_q[WORDS - 1], IFM_BASE + AB'(WORDS - 1));
      check("t1 init timing", init_cyc, wr_cyc_q[WORDS - 1] + 1);
      check("t1 init pulses", init_cnt, 1);
      check("t1 draining", {busy, io.s_ready}, 2'b10);
      pulse_done();
      wait_all("t1 all_done");
      check_results("t1", 1);
      check("t1 idle", busy, 0);

      // Three frames paced by acc_ready edges, four results offered
      clear_log();
      acc_ready = 1'b0;
      do_start(8'd3);
      tick(100);
      acc_ready = 1'b1;
      do_start(8'd5);
      wait_init(1, "t2 init 1");
      tick(20);
      check("t2 level hold writes", wr_addr_q.size(), WORDS);
      check("t2 level hold ready", io.s_ready, 0);
      pulse_done();
      check("t2 early result", fd_idx_q.size(), 1);
      acc_ready = 1'b0;
      tick(2);
      acc_ready = 1'b1;
      edge_cyc  = cyc;
      wait_init(2, "t2 init 2");
      check("t2 load 2 start", wr_cyc_q[WORDS], edge_cyc + 2);
      acc_ready = 1'b0;
      tick(2);
      acc_ready = 1'b1;
      edge_cyc  = cyc;
      wait_init(3, "t2 init 3");
      check("t2 load 3 start", wr_cyc_q[2 * WORDS], edge_cyc + 2);
      tick(5);
      check_writes("t2", 3);
      pulse_done();
      pulse_done();
      pulse_done();
      wait_all("t2 all_done");
      check_results("t2", 3);
      check("t2 init pulses", init_cnt, 3);
      check("t2 idle", busy, 0);
      acc_ready = 1'b0;

      // Single frame, stalling source
      clear_log();
      feed_pct = 50;
      do_start(8'd1);
      wait_init(1, "t3 init");
      tick(5);
      check_writes("t3", 1);
      pulse_done();
      wait_all("t3 all_done");
      check_results("t3", 1);

      // Empty job
      clear_log();
      do_start(8'd0);
      tick(4);
      check("t4 all_done count", all_done_cnt, 1);
      check("t4 all_done timing", all_done_cyc, start_cyc + 1);
      check("t4 busy cycles", busy_cnt, 0);
      check("t4 writes", wr_addr_q.size(), 0);

      // Reset in the middle of a load, then restart
      clear_log();
      feed_pct = 100;
      do_start(8'd1);
      for (int i = 0; i < FRAME_LIMIT && wr_addr_q.size() < 500; i++) tick(1);
      check("t5 reached word 500", wr_addr_q.size() >= 500, 1);
      reset = 1'b0;
      #1;
      check("t5 async bus", {io.bus_wr, io.bus_addr, io.bus_data}, 0);
      check("t5 async flags", {io.s_ready, busy, initialization_done, frame_done, all_done}, 5'b0);
      begin
         int n_at;
         n_at = wr_addr_q.size();
         tick(5);
         check("t5 no writes in reset", wr_addr_q.size(), n_at);
         check("t5 no init", init_cnt, 0);
      end
      reset = 1'b1;
      tick(2);
      clear_log();
      do_start(8'd1);
      wait_init(1, "t5 init");
      tick(3);
      check("t5 restart addr", wr_addr_q[0], IFM_BASE);
      check_writes("t5", 1);
      pulse_done();
      wait_all("t5 all_done");
      check_results("t5", 1);

      check("idle bus addr zero", addr_viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
